id_ex_operand_stage: RTL

- Decode/operand stage directly upstream of the 32-bit ALU (in1, in2, Binvert, Carryin, Operation).
- Holds the 32x32 MIPS register file with write-back bypass and decodes ALUOp/funct into ALU control bits.
- Registers everything into an ID/EX pipeline register with valid/ready stall and flush.
- Its ex_* outputs wire straight onto the ALU inputs.

---
 rtl/mips_pkg.sv | 39 +++
 rtl/regfile_2r1w.sv | 52 +++++
 rtl/id_ex_operand_stage.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encodings for the decode/operand stage: widths, ALUOp values,
// R-type funct codes and the ALU Operation field driven into the 32-bit ALU.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int REG_N  = 32;

  // ALUOp as produced by the main control unit.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,  // lw/sw address calculation
    ALUOP_SUB   = 2'b01,  // beq comparison
    ALUOP_RTYPE = 2'b10,  // look at funct
    ALUOP_RSVD  = 2'b11
  } aluop_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU Operation select (result mux inside the ALU).
  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SLT = 2'b11
  } alu_op_e;

  // Control bundle carried through the ID/EX register.
  typedef struct packed {
    logic    binvert;
    logic    carryin;
    alu_op_e operation;
    logic    illegal;
  } alu_ctrl_t;

endpackage

// File: rtl/regfile_2r1w.sv
// 2-read / 1-write register file with r0 hardwired to zero and a same-cycle
// write-back bypass so a reader never sees the value being overwritten.
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  input  logic              wen_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] mem_q [REG_N];

  // Register array: cleared on reset, written on the rising edge except r0.
  // NOTE: the array is reset explicitly because architectural state must read
  // as zero after reset; this rules out mapping it onto a RAM macro.
  // NOTE: sequential state uses <= so every entry updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wen_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports: r0 forced to zero, otherwise bypass a matching write-back.
  // NOTE: each output gets a value on every path, so no latch is inferred.
  always_comb begin
    rdata1_o = mem_q[raddr1_i];
    rdata2_o = mem_q[raddr2_i];
    if (raddr1_i == '0) begin
      rdata1_o = '0;
    end else if (wen_i && (waddr_i == raddr1_i)) begin
      rdata1_o = wdata_i;
    end
    if (raddr2_i == '0) begin
      rdata2_o = '0;
    end else if (wen_i && (waddr_i == raddr2_i)) begin
      rdata2_o = wdata_i;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: reads operands from the register file, decodes
// ALUOp/funct into ALU controls and registers both into a valid/ready
// pipeline register whose outputs drive the ALU directly.
module id_ex_operand_stage #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_N  = mips_pkg::REG_N,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic [1:0]        id_aluop,
  input  logic [5:0]        id_funct,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_in1,
  output logic [DATA_W-1:0] ex_in2,
  output logic              ex_binvert,
  output logic              ex_carryin,
  output logic [1:0]        ex_operation,
  output logic [ADDR_W-1:0] ex_rd,
  output logic              ex_illegal
);

  import mips_pkg::*;

  logic [DATA_W-1:0] rs_data, rt_data;
  alu_ctrl_t         ctrl_d, ctrl_q;
  aluop_e            aluop;
  logic              accept;
  logic              valid_d, valid_q;
  logic [DATA_W-1:0] in1_q, in2_q;
  logic [ADDR_W-1:0] rd_q;

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr1_i (id_rs),
    .raddr2_i (id_rt),
    .rdata1_o (rs_data),
    .rdata2_o (rt_data),
    .wen_i    (wb_en),
    .waddr_i  (wb_addr),
    .wdata_i  (wb_data)
  );

  assign aluop = aluop_e'(id_aluop);

  // ALU control decode; unsupported encodings fall back to ADD and flag illegal.
  always_comb begin
    ctrl_d = '{binvert: 1'b0, carryin: 1'b0, operation: OP_ADD, illegal: 1'b0};
    case (aluop)
      ALUOP_ADD: ;
      ALUOP_SUB: begin
        ctrl_d.binvert = 1'b1;
        ctrl_d.carryin = 1'b1;
      end
      ALUOP_RTYPE: begin
        case (id_funct)
          FUNCT_ADD: ;
          FUNCT_SUB: begin
            ctrl_d.binvert = 1'b1;
            ctrl_d.carryin = 1'b1;
          end
          FUNCT_AND: ctrl_d.operation = OP_AND;
          FUNCT_OR:  ctrl_d.operation = OP_OR;
          FUNCT_SLT: begin
            ctrl_d.binvert   = 1'b1;
            ctrl_d.carryin   = 1'b1;
            ctrl_d.operation = OP_SLT;
          end
          default:   ctrl_d.illegal = 1'b1;
        endcase
      end
      default: ctrl_d.illegal = 1'b1;
    endcase
  end

  // Handshake: accept when the register is empty or being drained; flush
  // overrides a same-cycle accept but never back-pressures upstream.
  always_comb begin
    id_ready = !valid_q || ex_ready;
    accept   = id_valid && id_ready;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (ex_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // ID/EX pipeline register: payload only moves on accept, so it holds
  // through stalls and keeps stale values once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      in1_q   <= '0;
      in2_q   <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        in1_q  <= rs_data;
        in2_q  <= rt_data;
        rd_q   <= id_rd;
        ctrl_q <= ctrl_d;
      end
    end
  end

  assign ex_valid     = valid_q;
  assign ex_in1       = in1_q;
  assign ex_in2       = in2_q;
  assign ex_rd        = rd_q;
  assign ex_binvert   = ctrl_q.binvert;
  assign ex_carryin   = ctrl_q.carryin;
  assign ex_operation = ctrl_q.operation;
  assign ex_illegal   = ctrl_q.illegal;

endmodule
